// File: rtl/rgb_frame_fetch_if.sv
// SRAM read bus plus outgoing pixel stream of the RGB frame fetcher.
// The master is the fetcher; the slave is the SRAM model / display side.
interface rgb_frame_fetch_if;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [7:0]  pix_R;
    logic [7:0]  pix_G;
    logic [7:0]  pix_B;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output SRAM_address, SRAM_we_n, pix_R, pix_G, pix_B, pix_valid,
        input  SRAM_read_data, pix_ready
    );

    modport slave (
        input  SRAM_address, SRAM_we_n, pix_R, pix_G, pix_B, pix_valid,
        output SRAM_read_data, pix_ready
    );
endinterface

// File: rtl/rgb_frame_fetch.sv
// Reads the packed RGB frame from SRAM, unpacks 3 words into 2 pixels, streams them via a FIFO.
// Optional macro RGB_FETCH_CHECKSUM_EN adds a 16-bit sum of all returned SRAM words.
module rgb_frame_fetch #(
    parameter logic [17:0] BASE_ADDR  = 18'd146944,
    parameter int          H_PIXELS   = 320,
    parameter int          V_LINES    = 240,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum,
    rgb_frame_fetch_if.master bus
);

    localparam int TOTAL_PAIRS = H_PIXELS * V_LINES / 2;
    localparam int PW = $clog2(TOTAL_PAIRS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE_0 = 3'd1;
    localparam logic [2:0] ISSUE_1 = 3'd2;
    localparam logic [2:0] ISSUE_2 = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;
    localparam logic [2:0] DRAIN   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]    state_r, next_state_s;
    logic [17:0]   addr_r, ptr_r;
    logic [PW-1:0] pair_cnt_r;
    logic [CW-1:0] inflight_r, fifo_cnt_r;
    logic [CW:0]   load_s;
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [23:0]   fifo_mem_r [FIFO_DEPTH];
    logic          tag0_vld_r, tag1_vld_r;
    logic [1:0]    tag0_idx_r, tag1_idx_r;
    logic [7:0]    r0_r, g0_r, r1_r;
    logic          busy_r, done_r;
    logic          credit_ok_s, issue_s, group_s, push_s, pop_s;
    logic [1:0]    issue_idx_s;
    logic [23:0]   push_data_s;

    // Credit: pixels already buffered or on their way must leave room for one more pair.
    assign load_s      = {1'b0, fifo_cnt_r} + {1'b0, inflight_r};
    assign credit_ok_s = (load_s <= (CW+1)'(FIFO_DEPTH - 2));
    assign group_s     = (next_state_s == ISSUE_0);
    assign pop_s       = (fifo_cnt_r != CW'(0)) && bus.pix_ready;

    // Next-state logic of the fetch sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = start ? HOLD : IDLE;
            HOLD:    next_state_s = credit_ok_s ? ISSUE_0 : HOLD;
            ISSUE_0: next_state_s = ISSUE_1;
            ISSUE_1: next_state_s = ISSUE_2;
            ISSUE_2: begin
                if (pair_cnt_r == PW'(TOTAL_PAIRS)) begin
                    next_state_s = DRAIN;
                end else if (credit_ok_s) begin
                    next_state_s = ISSUE_0;
                end else begin
                    next_state_s = HOLD;
                end
            end
            DRAIN: begin
                if ((inflight_r == CW'(0)) && (fifo_cnt_r == CW'(0))) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Which word of the pair (if any) is issued at the coming edge.
    always_comb begin
        issue_s     = 1'b0;
        issue_idx_s = 2'd0;
        case (next_state_s)
            ISSUE_0: begin issue_s = 1'b1; issue_idx_s = 2'd0; end
            ISSUE_1: begin issue_s = 1'b1; issue_idx_s = 2'd1; end
            ISSUE_2: begin issue_s = 1'b1; issue_idx_s = 2'd2; end
            default: begin issue_s = 1'b0; issue_idx_s = 2'd0; end
        endcase
    end

    // Unpack returning words; words 1 and 2 each complete a pixel.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = 24'd0;
        if (tag1_vld_r) begin
            case (tag1_idx_r)
                2'd1: begin
                    push_s      = 1'b1;
                    push_data_s = {r0_r, g0_r, bus.SRAM_read_data[15:8]};
                end
                2'd2: begin
                    push_s      = 1'b1;
                    push_data_s = {r1_r, bus.SRAM_read_data};
                end
                default: begin
                    push_s      = 1'b0;
                    push_data_s = 24'd0;
                end
            endcase
        end else begin
            push_s      = 1'b0;
            push_data_s = 24'd0;
        end
    end

    // Sequencer state, address pointer, pair counter and in-flight credit.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            addr_r     <= BASE_ADDR;
            ptr_r      <= 18'd0;
            pair_cnt_r <= PW'(0);
            inflight_r <= CW'(0);
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            busy_r     <= (next_state_s != IDLE) && (next_state_s != DONE);
            done_r     <= (next_state_s == DONE);
            inflight_r <= inflight_r + (group_s ? CW'(2) : CW'(0)) - (push_s ? CW'(1) : CW'(0));
            if (state_r == IDLE) begin
                ptr_r      <= 18'd0;
                pair_cnt_r <= PW'(0);
            end else begin
                if (issue_s) ptr_r <= ptr_r + 18'd1;
                if (group_s) pair_cnt_r <= pair_cnt_r + PW'(1);
            end
            if (issue_s) begin
                addr_r <= BASE_ADDR + ptr_r;
            end else if (next_state_s == IDLE) begin
                addr_r <= BASE_ADDR;
            end
        end
    end

    // Two-stage tag pipeline matching the SRAM read latency, plus partial-pixel latches.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            tag0_vld_r <= 1'b0;
            tag0_idx_r <= 2'd0;
            tag1_vld_r <= 1'b0;
            tag1_idx_r <= 2'd0;
            r0_r       <= 8'd0;
            g0_r       <= 8'd0;
            r1_r       <= 8'd0;
        end else begin
            tag0_vld_r <= issue_s;
            tag0_idx_r <= issue_idx_s;
            tag1_vld_r <= tag0_vld_r;
            tag1_idx_r <= tag0_idx_r;
            if (tag1_vld_r && (tag1_idx_r == 2'd0)) begin
                r0_r <= bus.SRAM_read_data[15:8];
                g0_r <= bus.SRAM_read_data[7:0];
            end
            if (tag1_vld_r && (tag1_idx_r == 2'd1)) begin
                r1_r <= bus.SRAM_read_data[7:0];
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            fifo_cnt_r <= CW'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge CLOCK_50_I) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= push_data_s;
    end

`ifdef RGB_FETCH_CHECKSUM_EN
    logic [15:0] chk_r;

    // Wrap-around sum of every returned word, restarted by each accepted start.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            chk_r <= 16'd0;
        end else if ((state_r == IDLE) && start) begin
            chk_r <= 16'd0;
        end else if (tag1_vld_r) begin
            chk_r <= chk_r + bus.SRAM_read_data;
        end
    end

    assign checksum = chk_r;
`else
    assign checksum = 16'd0;
`endif

    assign busy                             = busy_r;
    assign done                             = done_r;
    assign bus.SRAM_address                 = addr_r;
    assign bus.SRAM_we_n                    = 1'b1;
    assign bus.pix_valid                    = (fifo_cnt_r != CW'(0));
    assign {bus.pix_R, bus.pix_G, bus.pix_B} = bus.pix_valid ? fifo_mem_r[rd_ptr_r] : 24'd0;

endmodule

// File: tb/tb_rgb_frame_fetch.sv
// Directed bench for rgb_frame_fetch on a reduced 32x16 frame; SRAM word i = 0x1122 + i*0x2222.
module tb_rgb_frame_fetch;
    localparam logic [17:0] BASE  = 18'd146944;
    localparam int          HP    = 32;
    localparam int          VL    = 16;
    localparam int          PAIRS = HP * VL / 2;
    localparam int          NPIX  = 2 * PAIRS;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] checksum;
    logic [17:0] a1 = 18'd0;

    int vectors = 0;
    int miscompares = 0;
    int n_pop, done_cnt, lat, c;
    int unsigned sum;
    logic [17:0] max_addr;

    rgb_frame_fetch_if bus ();

    rgb_frame_fetch #(
        .BASE_ADDR (BASE),
        .H_PIXELS  (HP),
        .V_LINES   (VL),
        .FIFO_DEPTH(8)
    ) dut (
        .CLOCK_50_I(clk),
        .resetn    (resetn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] word_at(input int i);
        return 16'h1122 + 16'(i) * 16'h2222;
    endfunction

    function automatic logic [23:0] exp_pix(input int n);
        logic [15:0] w0, w1, w2;
        int k;
        k  = n / 2;
        w0 = word_at(3 * k);
        w1 = word_at(3 * k + 1);
        w2 = word_at(3 * k + 2);
        if (n % 2 == 0) return {w0, w1[15:8]};
        else            return {w1[7:0], w2};
    endfunction

    // SRAM: address registered one edge after it appears, data then valid for the following edge.
    always @(posedge clk) a1 <= bus.SRAM_address;
    assign bus.SRAM_read_data = word_at(int'(a1) - int'(BASE));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_stream(input int budget, input bit poke_start);
        int cc;
        cc       = 0;
        n_pop    = 0;
        done_cnt = 0;
        max_addr = bus.SRAM_address;
        while (done_cnt == 0 && cc < budget) begin
            if (bus.pix_valid && bus.pix_ready) begin
                if (n_pop < NPIX) chk("pixel", {bus.pix_R, bus.pix_G, bus.pix_B}, exp_pix(n_pop));
                n_pop++;
            end
            if (bus.SRAM_address > max_addr) max_addr = bus.SRAM_address;
            if (done) done_cnt++;
            if (poke_start) start = (cc == 100);
            @(negedge clk);
            cc++;
        end
        start = 1'b0;
        chk("done_within_budget", done_cnt, 1);
        repeat (6) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("done_once", done_cnt, 1);
        chk("pop_count", n_pop, NPIX);
        chk("last_addr", max_addr, BASE + 18'(3 * PAIRS - 1));
        chk("busy_after_done", busy, 0);
        chk("addr_back_to_base", bus.SRAM_address, BASE);
`ifdef RGB_FETCH_CHECKSUM_EN
        chk("checksum", checksum, sum & 32'h0000FFFF);
`else
        chk("checksum_tied", checksum, 0);
`endif
    endtask

    initial begin
        bus.pix_ready = 1'b0;
        sum = 0;
        for (int i = 0; i < 3 * PAIRS; i++) sum += word_at(i);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_addr", bus.SRAM_address, BASE);
        chk("rst_we_n", bus.SRAM_we_n, 1);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix", {bus.pix_R, bus.pix_G, bus.pix_B}, 0);
        chk("rst_checksum", checksum, 0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_addr", bus.SRAM_address, BASE);
        chk("idle_busy", busy, 0);

        // Frame 1: consumer always ready, one stray start mid-frame
        bus.pix_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        lat = 0;
        while (!bus.pix_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        chk("first_valid_latency", lat, 4);
        chk("first_pixel", {bus.pix_R, bus.pix_G, bus.pix_B}, 24'h112233);
        run_stream(3000, 1'b1);

        // Frame 2: consumer stalled, FIFO fills after four pairs
        bus.pix_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        chk("stall_addr", bus.SRAM_address, BASE + 18'd11);
        chk("stall_valid", bus.pix_valid, 1);
        chk("stall_head", {bus.pix_R, bus.pix_G, bus.pix_B}, 24'h112233);
        repeat (20) @(negedge clk);
        chk("stall_addr_held", bus.SRAM_address, BASE + 18'd11);
        chk("stall_head_held", {bus.pix_R, bus.pix_G, bus.pix_B}, 24'h112233);
        chk("stall_busy", busy, 1);
        bus.pix_ready = 1'b1;
        run_stream(3000, 1'b0);

        // Frame 3: reset around pair 100, then a clean restart
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (bus.SRAM_address < BASE + 18'd300 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("reached_pair_100", (bus.SRAM_address >= BASE + 18'd300), 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_addr", bus.SRAM_address, BASE);
        chk("midrst_valid", bus.pix_valid, 0);
        chk("midrst_busy", busy, 0);
        resetn = 1'b1;
        done_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_valid_idle", bus.pix_valid, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_stream(3000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
